// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, parity mode codes and baud divider helper
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    function automatic int baud_div(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_if.sv
// rtl/uart_if.sv - word-side TX push / RX strobe bundle between the register block and uart_core
interface uart_if #(
    parameter int DATA_BITS = 8,
    parameter int LEVEL_W   = 5
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [LEVEL_W-1:0]   tx_level;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_frame_err;
    logic                 rx_parity_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_level, tx_busy,
        input  rx_data, rx_valid, rx_frame_err, rx_parity_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_level, tx_busy,
        output rx_data, rx_valid, rx_frame_err, rx_parity_err
    );
endinterface

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous TX FIFO with wrap-bit pointers and occupancy output
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign level    = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - full-duplex UART engine with TX FIFO and RX error flags
// Optional parity generation/checking is built only when UART_PARITY_EN is defined.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ      = 24_000_000,
    parameter int UART_BPS      = 9600,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int TX_FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic [1:0] parity_mode,
    uart_if.slave      bus
);
    localparam int BAUD_DIV = baud_div(CLK_FREQ, UART_BPS);
    localparam int CW       = $clog2(BAUD_DIV);
    localparam int BW       = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.tx_valid),
        .push_data (bus.tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (bus.tx_level)
    );

    assign bus.tx_ready = !fifo_full;

    uart_state_t          tx_state, tx_next;
    logic [CW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_idx;
    logic                 tx_stop_idx;
    logic [DATA_BITS-1:0] tx_word;
    logic                 tx_tick, tx_line, tx_busy_q;

`ifdef UART_PARITY_EN
    logic tx_par_en, tx_par_odd;
    logic rx_par_en, rx_par_odd, rx_par_bit, rx_confirm, rx_par_take;
`else
    logic unused_parity;
    assign unused_parity = ^parity_mode;
`endif

    assign tx_tick     = (tx_cnt == BIT_LAST);
    assign bus.tx_busy = tx_busy_q;

    always_ff @(posedge clk) begin
        if (rst) tx_state <= IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            IDLE:   if (!fifo_empty) tx_next = START;
            START:  if (tx_tick) tx_next = DATA;
`ifdef UART_PARITY_EN
            DATA:   if (tx_tick && tx_idx == DATA_LAST) tx_next = tx_par_en ? PARITY : STOP;
            PARITY: if (tx_tick) tx_next = STOP;
`else
            DATA:   if (tx_tick && tx_idx == DATA_LAST) tx_next = STOP;
`endif
            STOP:   if (tx_tick && tx_stop_idx == STOP_LAST) tx_next = fifo_empty ? IDLE : START;
            default: tx_next = IDLE;
        endcase
    end

    // Popping straight out of STOP keeps queued frames back-to-back.
    always_comb begin
        fifo_pop = 1'b0;
        tx_line  = 1'b1;
        case (tx_state)
            IDLE:   fifo_pop = !fifo_empty;
            START:  tx_line  = 1'b0;
            DATA:   tx_line  = tx_word[tx_idx];
`ifdef UART_PARITY_EN
            PARITY: tx_line  = tx_par_odd ? ~^tx_word : ^tx_word;
`endif
            STOP:   fifo_pop = tx_tick && (tx_stop_idx == STOP_LAST) && !fifo_empty;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx          <= 1'b1;
            tx_busy_q   <= 1'b0;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_stop_idx <= 1'b0;
            tx_word     <= '0;
`ifdef UART_PARITY_EN
            tx_par_en   <= 1'b0;
            tx_par_odd  <= 1'b0;
`endif
        end else begin
            tx        <= tx_line;
            tx_busy_q <= (bus.tx_valid && !fifo_full) || !fifo_empty || (tx_state != IDLE);
            if (tx_state == IDLE || tx_next != tx_state || tx_tick) tx_cnt <= '0;
            else                                                    tx_cnt <= tx_cnt + 1'b1;
            if (tx_state != DATA) tx_idx <= '0;
            else if (tx_tick)     tx_idx <= tx_idx + 1'b1;
            if (tx_state != STOP) tx_stop_idx <= 1'b0;
            else if (tx_tick)     tx_stop_idx <= ~tx_stop_idx;
            if (fifo_pop) begin
                tx_word    <= fifo_data;
`ifdef UART_PARITY_EN
                tx_par_en  <= (parity_mode == PAR_ODD) || (parity_mode == PAR_EVEN);
                tx_par_odd <= (parity_mode == PAR_ODD);
`endif
            end
        end
    end

    logic                 rx_s1, rx_s2, rx_prev, rx_fall;
    uart_state_t          rx_state, rx_next;
    logic [CW-1:0]        rx_cnt;
    logic [BW-1:0]        rx_idx;
    logic [DATA_BITS-1:0] rx_shift, rx_data_q;
    logic                 rx_tick, rx_half, rx_shift_en, rx_done;
    logic                 rx_valid_q, rx_ferr_q, rx_perr_q;

    assign rx_fall = rx_prev && !rx_s2;
    assign rx_tick = (rx_cnt == BIT_LAST);
    assign rx_half = (rx_cnt == HALF_LAST);

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_frame_err  = rx_ferr_q;
    assign bus.rx_parity_err = rx_perr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rx_state <= IDLE;
        else     rx_state <= rx_next;
    end

    // Leaving STOP at mid-bit leaves half a bit-time to catch the next start edge.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:   if (rx_fall) rx_next = START;
            START:  if (rx_half) rx_next = rx_s2 ? IDLE : DATA;
`ifdef UART_PARITY_EN
            DATA:   if (rx_tick && rx_idx == DATA_LAST) rx_next = rx_par_en ? PARITY : STOP;
            PARITY: if (rx_tick) rx_next = STOP;
`else
            DATA:   if (rx_tick && rx_idx == DATA_LAST) rx_next = STOP;
`endif
            STOP:   if (rx_tick) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    always_comb begin
        rx_shift_en = 1'b0;
        rx_done     = 1'b0;
`ifdef UART_PARITY_EN
        rx_confirm  = 1'b0;
        rx_par_take = 1'b0;
`endif
        case (rx_state)
`ifdef UART_PARITY_EN
            START:  rx_confirm  = rx_half && !rx_s2;
            PARITY: rx_par_take = rx_tick;
`endif
            DATA:   rx_shift_en = rx_tick;
            STOP:   rx_done     = rx_tick;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_bit <= 1'b0;
`endif
        end else begin
            rx_valid_q <= rx_done;
            if (rx_state == IDLE || rx_next != rx_state || rx_tick) rx_cnt <= '0;
            else                                                    rx_cnt <= rx_cnt + 1'b1;
            if (rx_state != DATA) rx_idx <= '0;
            else if (rx_tick)     rx_idx <= rx_idx + 1'b1;
            if (rx_shift_en) rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
            if (rx_confirm) begin
                rx_par_en  <= (parity_mode == PAR_ODD) || (parity_mode == PAR_EVEN);
                rx_par_odd <= (parity_mode == PAR_ODD);
            end
            if (rx_par_take) rx_par_bit <= rx_s2;
`endif
            if (rx_done) begin
                rx_data_q <= rx_shift;
                rx_ferr_q <= !rx_s2;
`ifdef UART_PARITY_EN
                rx_perr_q <= rx_par_en && (rx_par_bit != (rx_par_odd ? ~^rx_shift : ^rx_shift));
`else
                rx_perr_q <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - scoreboard bench for uart_core at BAUD_DIV=16, 8 data bits, 1 stop bit
module tb_uart_core;

`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       has_par;
        logic       par;
        logic       b2b;
    } tx_exp_t;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } rx_exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       tx_mon_en = 1'b1;
    logic [1:0] parity_mode = 2'b00;
    logic       rx;
    logic       tx;

    int n_tests = 0;
    int n_fail = 0;
    int rx_strobes = 0;
    tx_exp_t tx_q[$];
    rx_exp_t rx_q[$];

    uart_if #(.DATA_BITS(8), .LEVEL_W(5)) bus ();

    assign rx = loop_en ? tx : rx_drv;

    uart_core #(
        .CLK_FREQ      (24_000_000),
        .UART_BPS      (1_500_000),
        .DATA_BITS     (8),
        .STOP_BITS     (1),
        .TX_FIFO_DEPTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .tx          (tx),
        .parity_mode (parity_mode),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        rx_drv = b;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic with_par, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (with_par) send_bit(par);
        send_bit(stop);
        rx_drv = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((bus.tx_busy !== 1'b0 || tx_q.size() != 0 || rx_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle_in_budget", 32'(n < budget), 32'd1);
        repeat (24) @(posedge clk);
        #1;
    endtask

    task automatic check_busy_fall(input int fall);
        repeat (fall - 1) @(posedge clk);
        #1;
        check("tx_busy_before_end", bus.tx_busy, 1'b1);
        @(posedge clk); #1;
        check("tx_busy_fall", bus.tx_busy, 1'b0);
    endtask

    // TX monitor: decodes each frame from the line and checks it against the queue.
    initial begin : tx_monitor
        int gap;
        tx_exp_t e;
        logic [7:0] d;
        gap = 1000;
        forever begin
            @(negedge clk);
            gap++;
            if (tx_mon_en && tx === 1'b0) begin
                if (tx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected_frame: got a start bit, expected no frame");
                    repeat (160) @(negedge clk);
                end else begin
                    e = tx_q.pop_front();
                    if (e.b2b) check("tx_b2b_gap", 32'(gap), 32'd8);
                    repeat (8) @(negedge clk);
                    check("tx_start_bit", tx, 1'b0);
                    for (int i = 0; i < 8; i++) begin
                        repeat (16) @(negedge clk);
                        d[i] = tx;
                    end
                    check("tx_data_bits", d, e.data);
                    if (e.has_par) begin
                        repeat (16) @(negedge clk);
                        check("tx_parity_bit", tx, e.par);
                    end
                    repeat (16) @(negedge clk);
                    check("tx_stop_bit", tx, 1'b1);
                end
                gap = 0;
            end
        end
    end

    always @(negedge clk) begin
        rx_exp_t e;
        if (bus.rx_valid === 1'b1) begin
            rx_strobes++;
            if (rx_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_unexpected_strobe: got rx_data 0x%0h, expected no strobe", bus.rx_data);
            end else begin
                e = rx_q.pop_front();
                check("rx_data", bus.rx_data, e.data);
                check("rx_frame_err", bus.rx_frame_err, e.ferr);
                check("rx_parity_err", bus.rx_parity_err, e.perr);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2000000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int lvl;
        int lows;
        int strobes0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_tx", tx, 1'b1);
        check("reset_tx_ready", bus.tx_ready, 1'b1);
        check("reset_tx_level", bus.tx_level, 5'd0);
        check("reset_tx_busy", bus.tx_busy, 1'b0);
        check("reset_rx_data", bus.rx_data, 8'h00);
        check("reset_rx_valid", bus.rx_valid, 1'b0);
        check("reset_rx_frame_err", bus.rx_frame_err, 1'b0);
        check("reset_rx_parity_err", bus.rx_parity_err, 1'b0);

        // 0xA5, no parity: pop at N+1, start bit at N+2, busy ends 160 clocks later
        parity_mode = 2'b00;
        tx_q.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
        push(8'hA5);
        check("tx_level_after_push", bus.tx_level, 5'd1);
        check("tx_busy_rise", bus.tx_busy, 1'b1);
        check("tx_idle_at_push", tx, 1'b1);
        @(posedge clk); #1;
        check("tx_level_after_pop", bus.tx_level, 5'd0);
        check("tx_idle_at_pop", tx, 1'b1);
        @(posedge clk); #1;
        check("tx_start_latency", tx, 1'b0);
        check_busy_fall(162 - 2);
        wait_idle(400);

        // 0x07 even parity: parity bit 1, 11 bit-times when parity is built in
        parity_mode = 2'b10;
        tx_q.push_back('{8'h07, PAR_EN, 1'b1, 1'b0});
        push(8'h07);
        check_busy_fall(2 + 16 * (10 + int'(PAR_EN)));
        wait_idle(400);

        // FIFO fill while word 0x40 is already on the line
        parity_mode = 2'b00;
        tx_q.push_back('{8'h40, 1'b0, 1'b0, 1'b0});
        push(8'h40);
        repeat (3) @(posedge clk);
        #1;
        lvl = 0;
        for (int i = 1; i <= 17; i++) begin
            bus.tx_data  = 8'(8'h40 + i);
            bus.tx_valid = 1'b1;
            check("tx_ready_fill", bus.tx_ready, 32'(lvl < 16));
            if (lvl < 16) begin
                tx_q.push_back('{8'(8'h40 + i), 1'b0, 1'b0, 1'b1});
                lvl++;
            end
            @(posedge clk); #1;
        end
        bus.tx_valid = 1'b0;
        check("tx_level_full", bus.tx_level, 5'd16);
        check("tx_ready_full", bus.tx_ready, 1'b0);
        wait_idle(4000);

        // loopback 0x3C odd parity
        loop_en = 1'b1;
        parity_mode = 2'b01;
        tx_q.push_back('{8'h3C, PAR_EN, 1'b1, 1'b0});
        rx_q.push_back('{8'h3C, 1'b0, 1'b0});
        push(8'h3C);
        wait_idle(600);
        loop_en = 1'b0;
        check("rx_loopback_held", bus.rx_data, 8'h3C);

        // stop bit low
        parity_mode = 2'b00;
        rx_q.push_back('{8'h5A, 1'b1, 1'b0});
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
        wait_idle(400);
        check("rx_frame_err_held", bus.rx_frame_err, 1'b1);

        // mode 11 behaves as none
        parity_mode = 2'b11;
        rx_q.push_back('{8'hC3, 1'b0, 1'b0});
        send_rx(8'hC3, 1'b0, 1'b0, 1'b1);
        wait_idle(400);

        // even parity with the wrong parity bit (0x07 needs 1)
        parity_mode = 2'b10;
        rx_q.push_back('{8'h07, 1'b0, PAR_EN});
        send_rx(8'h07, PAR_EN, 1'b0, 1'b1);
        wait_idle(400);
        check("rx_parity_err_held", bus.rx_parity_err, PAR_EN);
        check("rx_frame_err_cleared", bus.rx_frame_err, 1'b0);

        // 4-clock glitch must not produce a strobe
        strobes0 = rx_strobes;
        rx_drv = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("rx_glitch_reject", 32'(rx_strobes), 32'(strobes0));

        // reset during bit 3 of the first of five queued words
        tx_mon_en = 1'b0;
        parity_mode = 2'b00;
        for (int i = 0; i < 5; i++) push(8'(8'h81 + i));
        repeat (70) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_level", bus.tx_level, 5'd0);
        check("rst_mid_busy", bus.tx_busy, 1'b0);
        check("rst_mid_ready", bus.tx_ready, 1'b1);
        lows = 0;
        repeat (400) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) lows++;
        end
        check("rst_no_resume", 32'(lows), 32'd0);
        check("rst_busy_stays_low", bus.tx_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
